// File: rtl/mem_arbiter.sv
// Arbitrates instruction fetches and data accesses onto a single request/grant memory bus.
// Data side has fixed priority; every transaction is bounded by a request-to-response timeout.
module mem_arbiter #(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  Icache_ReqEn,
    input  logic [ADDR_WIDTH-1:0] Icache_Addr,
    output logic [31:0]           Icache_Instr,
    output logic                  Icache_Valid,
    output logic                  Icache_StallReq,
    input  logic                  Mem_DcacheEN,
    input  logic                  Mem_DcacheRd,
    input  logic [1:0]            Mem_DcacheWidth,
    input  logic                  Mem_DcacheSign,
    input  logic [ADDR_WIDTH-1:0] Mem_DcacheAddr,
    input  logic [31:0]           EXMem_Rs2Data,
    output logic [31:0]           Dcache_DataRd,
    output logic                  Dcache_Valid,
    output logic                  Dcache_StallReq,
    output logic                  Dcache_Misalign,
    output logic                  Bus_Req,
    output logic                  Bus_We,
    output logic [ADDR_WIDTH-1:0] Bus_Addr,
    output logic [31:0]           Bus_WrData,
    output logic [3:0]            Bus_ByteEn,
    input  logic                  Bus_Gnt,
    input  logic                  Bus_RValid,
    input  logic [31:0]           Bus_RData,
    output logic                  Bus_Err
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1) + 1;

    typedef enum logic [2:0] {IDLE, IREQ, IWAIT, DREQ, DWAIT} state_e;

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [1:0]              lane_q, lane_d;
    logic [1:0]              width_q, width_d;
    logic                    sign_q, sign_d;
    logic                    rd_q, rd_d;
    logic                    bus_req_q, bus_req_d;
    logic                    bus_we_q, bus_we_d;
    logic [ADDR_WIDTH-1:0]   bus_addr_q, bus_addr_d;
    logic [31:0]             bus_wrdata_q, bus_wrdata_d;
    logic [3:0]              bus_byteen_q, bus_byteen_d;
    logic                    bus_err_q, bus_err_d;
    logic                    i_valid_q, i_valid_d;
    logic [31:0]             i_instr_q, i_instr_d;
    logic                    d_valid_q, d_valid_d;
    logic [31:0]             d_data_q, d_data_d;
    logic                    d_mis_q, d_mis_d;
    logic                    d_misaligned_c;
    logic                    timeout_c;
    logic [1:0]              unused_iaddr_c;

    function automatic logic [3:0] byte_en(input logic [1:0] w, input logic [1:0] a);
        case (w)
            2'b00:   return 4'(4'b0001 << a);
            2'b01:   return 4'(4'b0011 << a);
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] wr_lanes(input logic [1:0] w, input logic [31:0] d);
        case (w)
            2'b00:   return {4{d[7:0]}};
            2'b01:   return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

    function automatic logic [31:0] load_ext(input logic [31:0] r, input logic [1:0] lane,
                                             input logic [1:0] w, input logic s);
        logic [31:0] sh;
        sh = r >> {lane, 3'b000};
        case (w)
            2'b00:   return {{24{s & sh[7]}}, sh[7:0]};
            2'b01:   return {{16{s & sh[15]}}, sh[15:0]};
            default: return r;
        endcase
    endfunction

    // Fetch addresses are word addresses; the low bits never reach the bus.
    assign unused_iaddr_c = Icache_Addr[1:0];

    assign d_misaligned_c = ((Mem_DcacheWidth == 2'b01) && Mem_DcacheAddr[0]) ||
                            (Mem_DcacheWidth[1] && (Mem_DcacheAddr[1:0] != 2'b00));
    assign timeout_c      = (cnt_q >= CNT_W'(TIMEOUT_CYCLES));

    // Next-state, capture and registered-output logic.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        lane_d       = lane_q;
        width_d      = width_q;
        sign_d       = sign_q;
        rd_d         = rd_q;
        bus_req_d    = 1'b0;
        bus_we_d     = bus_we_q;
        bus_addr_d   = bus_addr_q;
        bus_wrdata_d = bus_wrdata_q;
        bus_byteen_d = bus_byteen_q;
        bus_err_d    = 1'b0;
        i_valid_d    = 1'b0;
        i_instr_d    = i_instr_q;
        d_valid_d    = 1'b0;
        d_data_d     = d_data_q;
        d_mis_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (Mem_DcacheEN && !d_valid_q && !d_mis_q) begin
                    if (d_misaligned_c) begin
                        d_mis_d   = 1'b1;
                        d_valid_d = 1'b1;
                        d_data_d  = 32'h0;
                    end else begin
                        lane_d       = Mem_DcacheAddr[1:0];
                        width_d      = Mem_DcacheWidth;
                        sign_d       = Mem_DcacheSign;
                        rd_d         = Mem_DcacheRd;
                        bus_we_d     = ~Mem_DcacheRd;
                        bus_addr_d   = {Mem_DcacheAddr[ADDR_WIDTH-1:2], 2'b00};
                        bus_wrdata_d = wr_lanes(Mem_DcacheWidth, EXMem_Rs2Data);
                        bus_byteen_d = byte_en(Mem_DcacheWidth, Mem_DcacheAddr[1:0]);
                        bus_req_d    = 1'b1;
                        cnt_d        = '0;
                        state_d      = DREQ;
                    end
                end else if (Icache_ReqEn && !i_valid_q) begin
                    bus_we_d     = 1'b0;
                    bus_addr_d   = {Icache_Addr[ADDR_WIDTH-1:2], 2'b00};
                    bus_wrdata_d = 32'h0;
                    bus_byteen_d = 4'b1111;
                    bus_req_d    = 1'b1;
                    cnt_d        = '0;
                    state_d      = IREQ;
                end
            end
            IREQ, DREQ: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (Bus_Gnt) begin
                    state_d = (state_q == DREQ) ? DWAIT : IWAIT;
                end else if (timeout_c) begin
                    state_d   = IDLE;
                    bus_err_d = 1'b1;
                    if (state_q == DREQ) begin
                        d_valid_d = 1'b1;
                        d_data_d  = 32'h0;
                    end else begin
                        i_valid_d = 1'b1;
                        i_instr_d = 32'h0;
                    end
                end else begin
                    bus_req_d = 1'b1;
                end
            end
            IWAIT, DWAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (Bus_RValid || timeout_c) begin
                    state_d   = IDLE;
                    bus_err_d = ~Bus_RValid;
                    if (state_q == DWAIT) begin
                        d_valid_d = 1'b1;
                        d_data_d  = (Bus_RValid && rd_q) ?
                                    load_ext(Bus_RData, lane_q, width_q, sign_q) : 32'h0;
                    end else begin
                        i_valid_d = 1'b1;
                        i_instr_d = Bus_RValid ? Bus_RData : 32'h0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            lane_q       <= 2'b00;
            width_q      <= 2'b00;
            sign_q       <= 1'b0;
            rd_q         <= 1'b0;
            bus_req_q    <= 1'b0;
            bus_we_q     <= 1'b0;
            bus_addr_q   <= '0;
            bus_wrdata_q <= 32'h0;
            bus_byteen_q <= 4'h0;
            bus_err_q    <= 1'b0;
            i_valid_q    <= 1'b0;
            i_instr_q    <= 32'h0;
            d_valid_q    <= 1'b0;
            d_data_q     <= 32'h0;
            d_mis_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            lane_q       <= lane_d;
            width_q      <= width_d;
            sign_q       <= sign_d;
            rd_q         <= rd_d;
            bus_req_q    <= bus_req_d;
            bus_we_q     <= bus_we_d;
            bus_addr_q   <= bus_addr_d;
            bus_wrdata_q <= bus_wrdata_d;
            bus_byteen_q <= bus_byteen_d;
            bus_err_q    <= bus_err_d;
            i_valid_q    <= i_valid_d;
            i_instr_q    <= i_instr_d;
            d_valid_q    <= d_valid_d;
            d_data_q     <= d_data_d;
            d_mis_q      <= d_mis_d;
        end
    end

    assign Bus_Req         = bus_req_q;
    assign Bus_We          = bus_we_q;
    assign Bus_Addr        = bus_addr_q;
    assign Bus_WrData      = bus_wrdata_q;
    assign Bus_ByteEn      = bus_byteen_q;
    assign Bus_Err         = bus_err_q;
    assign Icache_Valid    = i_valid_q;
    assign Icache_Instr    = i_instr_q;
    assign Dcache_Valid    = d_valid_q;
    assign Dcache_DataRd   = d_data_q;
    assign Dcache_Misalign = d_mis_q;
    assign Icache_StallReq = Icache_ReqEn & ~i_valid_q;
    assign Dcache_StallReq = Mem_DcacheEN & ~d_valid_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a bus responder checks issued requests,
// a monitor checks every Valid strobe against queued expectations.
module tb_mem_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned TO = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          Icache_ReqEn;
    logic [AW-1:0] Icache_Addr;
    logic [31:0]   Icache_Instr;
    logic          Icache_Valid, Icache_StallReq;
    logic          Mem_DcacheEN, Mem_DcacheRd, Mem_DcacheSign;
    logic [1:0]    Mem_DcacheWidth;
    logic [AW-1:0] Mem_DcacheAddr;
    logic [31:0]   EXMem_Rs2Data, Dcache_DataRd;
    logic          Dcache_Valid, Dcache_StallReq, Dcache_Misalign;
    logic          Bus_Req, Bus_We, Bus_Gnt, Bus_RValid, Bus_Err;
    logic [AW-1:0] Bus_Addr;
    logic [31:0]   Bus_WrData, Bus_RData;
    logic [3:0]    Bus_ByteEn;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .Icache_ReqEn(Icache_ReqEn), .Icache_Addr(Icache_Addr), .Icache_Instr(Icache_Instr),
        .Icache_Valid(Icache_Valid), .Icache_StallReq(Icache_StallReq),
        .Mem_DcacheEN(Mem_DcacheEN), .Mem_DcacheRd(Mem_DcacheRd), .Mem_DcacheWidth(Mem_DcacheWidth),
        .Mem_DcacheSign(Mem_DcacheSign), .Mem_DcacheAddr(Mem_DcacheAddr), .EXMem_Rs2Data(EXMem_Rs2Data),
        .Dcache_DataRd(Dcache_DataRd), .Dcache_Valid(Dcache_Valid), .Dcache_StallReq(Dcache_StallReq),
        .Dcache_Misalign(Dcache_Misalign),
        .Bus_Req(Bus_Req), .Bus_We(Bus_We), .Bus_Addr(Bus_Addr), .Bus_WrData(Bus_WrData),
        .Bus_ByteEn(Bus_ByteEn), .Bus_Gnt(Bus_Gnt), .Bus_RValid(Bus_RValid), .Bus_RData(Bus_RData),
        .Bus_Err(Bus_Err)
    );

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic        we;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } bus_t;

    typedef struct {
        logic        is_d;
        logic [31:0] data;
        logic        err;
        logic        mis;
    } rsp_t;

    bus_t bus_q[$];
    rsp_t rsp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    bit   withhold_gnt = 1'b0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic m_misal(input logic [1:0] w, input logic [31:0] a);
        if (w == 2'b01) return a[0];
        if (w[1])       return a[1:0] != 2'b00;
        return 1'b0;
    endfunction

    function automatic logic [31:0] m_load(input logic [1:0] w, input logic s,
                                           input logic [1:0] a, input logic [31:0] r);
        logic [7:0]  b;
        logic [15:0] h;
        case (a)
            2'd0:    b = r[7:0];
            2'd1:    b = r[15:8];
            2'd2:    b = r[23:16];
            default: b = r[31:24];
        endcase
        h = a[1] ? r[31:16] : r[15:0];
        if (w == 2'b00) return s ? 32'($signed(b)) : {24'h0, b};
        if (w == 2'b01) return s ? 32'($signed(h)) : {16'h0, h};
        return r;
    endfunction

    task automatic push_bus(input logic [31:0] a, input logic [3:0] be, input logic we,
                            input logic [31:0] wd, input logic [31:0] rd);
        bus_t b;
        b.addr = a; b.be = be; b.we = we; b.wdata = wd; b.rdata = rd;
        bus_q.push_back(b);
    endtask

    task automatic push_rsp(input logic is_d, input logic [31:0] data, input logic err, input logic mis);
        rsp_t r;
        r.is_d = is_d; r.data = data; r.err = err; r.mis = mis;
        rsp_q.push_back(r);
    endtask

    // Model-derived expectations for randomised data accesses.
    task automatic exp_d(input logic rd, input logic [1:0] w, input logic s,
                         input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rdata);
        logic [3:0]  be;
        logic [31:0] lanes;
        if (m_misal(w, a)) begin
            push_rsp(1'b1, 32'h0, 1'b0, 1'b1);
        end else begin
            case (w)
                2'b00:   begin be = 4'b0001 << a[1:0]; lanes = {wd[7:0], wd[7:0], wd[7:0], wd[7:0]}; end
                2'b01:   begin be = a[1] ? 4'b1100 : 4'b0011; lanes = {wd[15:0], wd[15:0]}; end
                default: begin be = 4'b1111; lanes = wd; end
            endcase
            push_bus(a & 32'hFFFF_FFFC, be, ~rd, lanes, rdata);
            push_rsp(1'b1, rd ? m_load(w, s, a[1:0], rdata) : 32'h0, 1'b0, 1'b0);
        end
    endtask

    task automatic d_req(input logic rd, input logic [1:0] w, input logic s,
                         input logic [31:0] a, input logic [31:0] wd, input bit scr);
        bit got = 1'b0;
        Mem_DcacheEN = 1'b1; Mem_DcacheRd = rd; Mem_DcacheWidth = w;
        Mem_DcacheSign = s; Mem_DcacheAddr = a; EXMem_Rs2Data = wd;
        #1 chk("d_stall_pending", 32'(Dcache_StallReq), 32'd1);
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (scr && i == 2 && !Dcache_Valid) begin
                Mem_DcacheAddr = ~a; EXMem_Rs2Data = ~wd;
                Mem_DcacheSign = ~s; Mem_DcacheWidth = ~w;
            end
            if (Dcache_Valid) begin
                chk("d_stall_valid", 32'(Dcache_StallReq), 32'd0);
                got = 1'b1;
                break;
            end
        end
        if (!got) chk("d_valid_timeout", 32'(Dcache_Valid), 32'd1);
        Mem_DcacheEN = 1'b0;
        @(negedge clk);
    endtask

    task automatic i_req(input logic [31:0] a, input bit scr);
        bit got = 1'b0;
        Icache_ReqEn = 1'b1; Icache_Addr = a;
        #1 chk("i_stall_pending", 32'(Icache_StallReq), 32'd1);
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (scr && i == 2 && !Icache_Valid) Icache_Addr = ~a;
            if (Icache_Valid) begin
                chk("i_stall_valid", 32'(Icache_StallReq), 32'd0);
                got = 1'b1;
                break;
            end
        end
        if (!got) chk("i_valid_timeout", 32'(Icache_Valid), 32'd1);
        Icache_ReqEn = 1'b0;
        @(negedge clk);
    endtask

    // Bus responder: Gnt one cycle after Req is seen, RValid two cycles after Gnt.
    initial begin
        bus_t b;
        Bus_Gnt = 1'b0; Bus_RValid = 1'b0; Bus_RData = 32'h0;
        forever begin
            @(negedge clk);
            if (rst_n && Bus_Req && !withhold_gnt) begin
                if (bus_q.size() == 0) begin
                    chk("bus_unexpected_req", 32'(Bus_Req), 32'd0);
                end else begin
                    b = bus_q.pop_front();
                    chk("bus_addr", Bus_Addr, b.addr);
                    chk("bus_byteen", 32'(Bus_ByteEn), 32'(b.be));
                    chk("bus_we", 32'(Bus_We), 32'(b.we));
                    if (b.we) chk("bus_wrdata", Bus_WrData, b.wdata);
                    @(negedge clk); Bus_Gnt = 1'b1;
                    @(negedge clk); Bus_Gnt = 1'b0;
                    if (rst_n) chk("bus_req_in_wait", 32'(Bus_Req), 32'd0);
                    @(negedge clk); Bus_RValid = 1'b1; Bus_RData = b.rdata;
                    @(negedge clk); Bus_RValid = 1'b0; Bus_RData = 32'hA5A5_5A5A;
                end
            end
        end
    end

    // Response monitor.
    initial begin
        rsp_t r;
        forever begin
            @(negedge clk);
            if (Icache_Valid || Dcache_Valid) begin
                if (rsp_q.size() == 0) begin
                    chk("valid_unexpected", {30'h0, Icache_Valid, Dcache_Valid}, 32'd0);
                end else begin
                    r = rsp_q.pop_front();
                    chk("valid_port", {30'h0, Icache_Valid, Dcache_Valid}, r.is_d ? 32'd1 : 32'd2);
                    chk("rsp_data", r.is_d ? Dcache_DataRd : Icache_Instr, r.data);
                    chk("bus_err", 32'(Bus_Err), 32'(r.err));
                    chk("misalign", 32'(Dcache_Misalign), 32'(r.mis));
                    if (r.err) chk("req_after_timeout", 32'(Bus_Req), 32'd0);
                end
            end else begin
                chk("stray_strobe", {30'h0, Bus_Err, Dcache_Misalign}, 32'd0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", n_errors);
        $fatal(1);
    end

    initial begin
        logic [1:0]  w;
        logic [31:0] a, wd, rdata;
        logic        rd, s;
        bit          got;
        rst_n = 1'b0;
        Icache_ReqEn = 1'b0; Icache_Addr = '0;
        Mem_DcacheEN = 1'b0; Mem_DcacheRd = 1'b0; Mem_DcacheWidth = 2'b00;
        Mem_DcacheSign = 1'b0; Mem_DcacheAddr = '0; EXMem_Rs2Data = 32'h0;
        repeat (3) @(negedge clk);
        chk("rst_bus_req", 32'(Bus_Req), 32'd0);
        chk("rst_bus_addr", Bus_Addr, 32'h0);
        chk("rst_bus_be", 32'(Bus_ByteEn), 32'd0);
        chk("rst_valids", {30'h0, Icache_Valid, Dcache_Valid}, 32'd0);
        chk("rst_ddata", Dcache_DataRd, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        push_bus(32'h100, 4'b1111, 1'b0, 32'h0, 32'h0000_0013);
        push_rsp(1'b0, 32'h0000_0013, 1'b0, 1'b0);
        i_req(32'h100, 1'b1);

        push_bus(32'h200, 4'b1000, 1'b0, 32'h0, 32'h80AA_BBCC);
        push_rsp(1'b1, 32'hFFFF_FF80, 1'b0, 1'b0);
        d_req(1'b1, 2'b00, 1'b1, 32'h203, 32'h0, 1'b1);
        push_bus(32'h200, 4'b1000, 1'b0, 32'h0, 32'h80AA_BBCC);
        push_rsp(1'b1, 32'h0000_0080, 1'b0, 1'b0);
        d_req(1'b1, 2'b00, 1'b0, 32'h203, 32'h0, 1'b1);

        push_bus(32'h400, 4'b1100, 1'b1, 32'h1234_1234, 32'h0);
        push_rsp(1'b1, 32'h0, 1'b0, 1'b0);
        d_req(1'b0, 2'b01, 1'b0, 32'h402, 32'h5555_1234, 1'b1);

        push_rsp(1'b1, 32'h0, 1'b0, 1'b1);
        d_req(1'b1, 2'b10, 1'b0, 32'h401, 32'h0, 1'b1);

        // Simultaneous requests: data side must be served first.
        push_bus(32'h500, 4'b1111, 1'b0, 32'h0, 32'hDEAD_BEEF);
        push_rsp(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0);
        push_bus(32'h600, 4'b1111, 1'b0, 32'h0, 32'h1111_1111);
        push_rsp(1'b0, 32'h1111_1111, 1'b0, 1'b0);
        fork
            d_req(1'b1, 2'b10, 1'b0, 32'h500, 32'h0, 1'b1);
            i_req(32'h600, 1'b0);
        join

        withhold_gnt = 1'b1;
        push_rsp(1'b0, 32'h0, 1'b1, 1'b0);
        i_req(32'h800, 1'b1);
        withhold_gnt = 1'b0;

        // Reset during DWAIT abandons the load with no strobe.
        push_bus(32'h700, 4'b1111, 1'b0, 32'h0, 32'hCAFE_F00D);
        Mem_DcacheEN = 1'b1; Mem_DcacheRd = 1'b1; Mem_DcacheWidth = 2'b10;
        Mem_DcacheSign = 1'b0; Mem_DcacheAddr = 32'h700;
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (Bus_Gnt) begin got = 1'b1; break; end
        end
        if (!got) chk("rst_test_gnt_timeout", 32'(Bus_Gnt), 32'd1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_bus_req", 32'(Bus_Req), 32'd0);
        chk("midrst_bus_addr", Bus_Addr, 32'h0);
        chk("midrst_ddata", Dcache_DataRd, 32'h0);
        chk("midrst_valids", {30'h0, Icache_Valid, Dcache_Valid}, 32'd0);
        Mem_DcacheEN = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);

        for (int n = 0; n < 12; n++) begin
            rdata = $urandom;
            if (n % 3 == 2) begin
                a = $urandom & 32'h0000_FFFC;
                push_bus(a, 4'b1111, 1'b0, 32'h0, rdata);
                push_rsp(1'b0, rdata, 1'b0, 1'b0);
                i_req(a | 32'(n & 3), 1'b1);
            end else begin
                w  = 2'($urandom_range(0, 2));
                rd = 1'($urandom);
                s  = 1'($urandom);
                a  = $urandom & 32'h0000_FFFF;
                wd = $urandom;
                exp_d(rd, w, s, a, wd, rdata);
                d_req(rd, w, s, a, wd, 1'b1);
            end
        end

        repeat (4) @(negedge clk);
        chk("bus_queue_drained", 32'(bus_q.size()), 32'd0);
        chk("rsp_queue_drained", 32'(rsp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
